// File: rtl/ram_stream_seq.sv
// Flow-controlled front end for a single-port, async-read RAM: a fill stream is written to
// consecutive addresses from 0 and the same region can be read back as an output stream.
module ram_stream_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start_wr_i,
    input  logic              start_rd_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_wen_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    // state      | meaning
    // S_IDLE     | waiting for a start request
    // S_WR_WAIT  | fill: ready for the next byte
    // S_WR_PULSE | fill: write enable high for exactly one cycle
    // S_WR_GAP   | fill: address/data held, pointer advances
    // S_RD_ADDR  | dump: present pointer on the RAM address
    // S_RD_CAP   | dump: capture the RAM read data
    // S_RD_OUT   | dump: hold the word until the consumer takes it
    // S_DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_WR_WAIT, S_WR_PULSE, S_WR_GAP, S_RD_ADDR, S_RD_CAP, S_RD_OUT, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state, state_d;
    logic [ADDR_W:0]   ptr, ptr_d, cnt, cnt_d, ptr_inc, len_clamp;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d, odata_d;
    logic              wen_d, ovalid_d;

    assign ptr_inc   = ptr + {{ADDR_W{1'b0}}, 1'b1};
    assign len_clamp = (len_i > DEPTH_C) ? DEPTH_C : len_i;

    assign in_ready_o = (state == S_WR_WAIT);
    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        cnt_d    = cnt;
        addr_d   = ram_addr_o;
        data_d   = ram_data_o;
        wen_d    = 1'b0;
        odata_d  = out_data_o;
        ovalid_d = out_valid_o;
        case (state)
            S_IDLE: begin
                if (start_wr_i || start_rd_i) begin
                    cnt_d = len_clamp;
                    ptr_d = '0;
                    // A zero-length request completes without touching RAM or streams.
                    if (len_i == '0)
                        state_d = S_DONE;
                    else if (start_wr_i)
                        state_d = S_WR_WAIT;
                    else
                        state_d = S_RD_ADDR;
                end
            end
            S_WR_WAIT: begin
                if (in_valid_i) begin
                    addr_d  = ptr[ADDR_W-1:0];
                    data_d  = in_data_i;
                    wen_d   = 1'b1;
                    state_d = S_WR_PULSE;
                end
            end
            S_WR_PULSE: state_d = S_WR_GAP;
            S_WR_GAP: begin
                ptr_d   = ptr_inc;
                state_d = (ptr_inc == cnt) ? S_DONE : S_WR_WAIT;
            end
            S_RD_ADDR: begin
                addr_d  = ptr[ADDR_W-1:0];
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                odata_d  = ram_data_i;
                ovalid_d = 1'b1;
                state_d  = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (out_ready_i) begin
                    ovalid_d = 1'b0;
                    ptr_d    = ptr_inc;
                    state_d  = (ptr_inc == cnt) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            ram_wen_o   <= 1'b0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            ram_addr_o  <= addr_d;
            ram_data_o  <= data_d;
            ram_wen_o   <= wen_d;
            out_data_o  <= odata_d;
            out_valid_o <= ovalid_d;
        end
    end

endmodule

// File: tb/tb_ram_stream_seq.sv
// Bench for ram_stream_seq: behavioural RAM, queue scoreboards for RAM writes and dump words.
module tb_ram_stream_seq;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              start_wr_i, start_rd_i;
    logic [ADDR_W:0]   len_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_valid_i, in_ready_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o, out_ready_i;
    logic              busy_o, done_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_o, ram_data_i;
    logic              ram_wen_o;

    ram_stream_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .start_wr_i(start_wr_i), .start_rd_i(start_rd_i), .len_i(len_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_wen_o(ram_wen_o), .ram_data_i(ram_data_i)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    always @(posedge Clk) if (ram_wen_o) mem[ram_addr_o] <= ram_data_o;
    assign ram_data_i = mem[ram_addr_o];

    int total = 0;
    int bad = 0;
    logic [17:0] wq[$];
    logic [7:0]  rq[$];

    task automatic test_reset;
        Rst = 1'b1; start_wr_i = 0; start_rd_i = 0; len_i = '0;
        in_data_i = '0; in_valid_i = 0; out_ready_i = 0;
        repeat (2) @(negedge Clk);
        total++;
        if ({ram_addr_o, ram_data_o, ram_wen_o, out_data_o, out_valid_o, done_o, busy_o, in_ready_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got addr=%h data=%h wen=%b odata=%h ovalid=%b done=%b busy=%b rdy=%b want all 0",
                     ram_addr_o, ram_data_o, ram_wen_o, out_data_o, out_valid_o, done_o, busy_o, in_ready_o);
        end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_fill;
        int sent = 0;
        int pulses = 0;
        logic [17:0] e;
        start_wr_i = 1; len_i = 11'd5;
        @(negedge Clk);
        start_wr_i = 0;
        for (int c = 0; c < 100; c++) begin
            if (ram_wen_o) begin
                e = wq.pop_front();
                total++;
                if ({ram_addr_o, ram_data_o} !== e) begin
                    bad++;
                    $display("FAIL mid_fill_write: got %h want %h", {ram_addr_o, ram_data_o}, e);
                end
                pulses++;
            end
            if (pulses == 3) break;
            in_valid_i = (sent < 3);
            in_data_i  = 8'h30 + 8'(sent);
            if (in_valid_i && in_ready_o) begin
                wq.push_back({10'(sent), in_data_i});
                exp_mem[sent] = in_data_i;
                sent++;
            end
            @(negedge Clk);
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL mid_fill_pulses: got %0d want 3", pulses);
        end
        in_valid_i = 0;
        Rst = 1;
        repeat (2) @(negedge Clk);
        total++;
        if ({ram_addr_o, ram_data_o, ram_wen_o, out_data_o, out_valid_o, done_o, busy_o, in_ready_o} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got addr=%h data=%h wen=%b busy=%b rdy=%b want all 0",
                     ram_addr_o, ram_data_o, ram_wen_o, busy_o, in_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL abort_ram[%0d]: got %h want %h", i, mem[i], exp_mem[i]);
            end
        end
        Rst = 0;
        start_wr_i = 1; len_i = 11'd1;
        @(negedge Clk);
        start_wr_i = 0;
        total++;
        if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL restart_accept: got busy=%b rdy=%b want 1 1", busy_o, in_ready_o);
        end
        in_valid_i = 1; in_data_i = 8'h5A;
        exp_mem[0] = 8'h5A;
        @(negedge Clk);
        in_valid_i = 0;
        for (int c = 0; c < 10 && !done_o; c++) @(negedge Clk);
        total++;
        if (done_o !== 1'b1 || mem[0] !== 8'h5A) begin
            bad++;
            $display("FAIL restart_done: got done=%b ram0=%h want 1 5a", done_o, mem[0]);
        end
        @(negedge Clk);
    endtask

    task automatic test_fill;
        int sent = 0;
        int pulses = 0;
        int last_c = 0;
        logic prev_wen = 0;
        logic got_done = 0;
        logic [17:0] e;
        start_wr_i = 1; len_i = 11'd4;
        @(negedge Clk);
        start_wr_i = 0;
        for (int c = 0; c < 100; c++) begin
            if (prev_wen && ram_wen_o) begin
                total++; bad++;
                $display("FAIL fill_wen_width: got 2 consecutive cycles want 1");
            end
            if (ram_wen_o) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL fill_extra_write: got addr=%h data=%h want none", ram_addr_o, ram_data_o);
                end else begin
                    e = wq.pop_front();
                    if ({ram_addr_o, ram_data_o} !== e) begin
                        bad++;
                        $display("FAIL fill_write: got %h want %h", {ram_addr_o, ram_data_o}, e);
                    end
                end
                if (pulses > 0) begin
                    total++;
                    if (c - last_c != 3) begin
                        bad++;
                        $display("FAIL fill_spacing: got %0d want 3", c - last_c);
                    end
                end
                last_c = c;
                pulses++;
            end
            prev_wen = ram_wen_o;
            if (done_o) begin got_done = 1; break; end
            in_valid_i = (sent < 4);
            in_data_i  = 8'hA0 + 8'(sent);
            if (in_valid_i && in_ready_o) begin
                wq.push_back({10'(sent), in_data_i});
                exp_mem[sent] = in_data_i;
                sent++;
            end
            @(negedge Clk);
        end
        in_valid_i = 0;
        total++;
        if (!got_done || pulses != 4 || wq.size() != 0) begin
            bad++;
            $display("FAIL fill_complete: got done=%b pulses=%0d left=%0d want 1 4 0", got_done, pulses, wq.size());
        end
        @(negedge Clk);
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL fill_idle: got done=%b busy=%b want 0 0", done_o, busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[i] !== 8'hA0 + 8'(i)) begin
                bad++;
                $display("FAIL fill_ram[%0d]: got %h want %h", i, mem[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_dump(input int len, input bit toggle);
        int hs = 0;
        logic hold = 0;
        logic got_done = 0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        for (int i = 0; i < len; i++) rq.push_back(exp_mem[i]);
        start_rd_i = 1; len_i = 11'(len);
        @(negedge Clk);
        start_rd_i = 0;
        for (int c = 0; c < 300; c++) begin
            out_ready_i = toggle ? (c % 4 == 3) : 1'b1;
            if (ram_wen_o !== 1'b0) begin
                total++; bad++;
                $display("FAIL dump_wen: got %b want 0", ram_wen_o);
            end
            if (hold) begin
                total++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
                    bad++;
                    $display("FAIL dump_hold: got valid=%b data=%h want 1 %h", out_valid_o, out_data_o, prev_data);
                end
            end
            if (out_valid_o && out_ready_i) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL dump_extra: got %h want none", out_data_o);
                end else begin
                    e = rq.pop_front();
                    if (out_data_o !== e) begin
                        bad++;
                        $display("FAIL dump_data: got %h want %h", out_data_o, e);
                    end
                end
                hs++;
            end
            hold = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            if (done_o) begin got_done = 1; break; end
            @(negedge Clk);
        end
        out_ready_i = 0;
        total++;
        if (!got_done || hs != len || rq.size() != 0) begin
            bad++;
            $display("FAIL dump_complete: got done=%b words=%0d left=%0d want 1 %0d 0", got_done, hs, rq.size(), len);
        end
        rq.delete();
        @(negedge Clk);
    endtask

    task automatic test_len_zero_both;
        start_wr_i = 1; start_rd_i = 1; len_i = '0;
        @(negedge Clk);
        start_wr_i = 0; start_rd_i = 0;
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || ram_wen_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_done: got done=%b busy=%b wen=%b rdy=%b want 1 1 0 0",
                     done_o, busy_o, ram_wen_o, in_ready_o);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            total++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || ram_wen_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL zero_len_after: got done=%b busy=%b wen=%b rdy=%b ovalid=%b want all 0",
                         done_o, busy_o, ram_wen_o, in_ready_o, out_valid_o);
            end
        end
    endtask

    task automatic test_full_fill;
        int sent = 0;
        int pulses = 0;
        int last_c = 0;
        int done_c = 0;
        logic got_done = 0;
        logic saw_ovalid = 0;
        logic [17:0] last = '0;
        logic [17:0] e;
        start_wr_i = 1; len_i = 11'd1100;
        @(negedge Clk);
        start_wr_i = 0;
        for (int c = 0; c < 5000; c++) begin
            start_rd_i = (c == 10);
            if (out_valid_o) saw_ovalid = 1;
            if (ram_wen_o) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL full_extra_write: got addr=%h data=%h want none", ram_addr_o, ram_data_o);
                end else begin
                    e = wq.pop_front();
                    total++;
                    if ({ram_addr_o, ram_data_o} !== e) begin
                        bad++;
                        $display("FAIL full_write: got %h want %h", {ram_addr_o, ram_data_o}, e);
                    end
                end
                last = {ram_addr_o, ram_data_o};
                last_c = c;
                pulses++;
            end
            if (done_o) begin got_done = 1; done_c = c; break; end
            in_valid_i = (sent < DEPTH);
            in_data_i  = 8'(sent);
            if (in_valid_i && in_ready_o) begin
                wq.push_back({10'(sent), in_data_i});
                sent++;
            end
            @(negedge Clk);
        end
        in_valid_i = 0; start_rd_i = 0;
        total++;
        if (!got_done || pulses != DEPTH || wq.size() != 0) begin
            bad++;
            $display("FAIL full_complete: got done=%b writes=%0d left=%0d want 1 1024 0", got_done, pulses, wq.size());
        end
        total++;
        if (last !== {10'd1023, 8'hFF} || done_c - last_c != 2) begin
            bad++;
            $display("FAIL full_last: got %h gap=%0d want %h gap=2", last, done_c - last_c, {10'd1023, 8'hFF});
        end
        wq.delete();
        @(negedge Clk);
        total++;
        if (busy_o !== 1'b0 || saw_ovalid || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL full_rd_ignored: got busy=%b ovalid_seen=%b want 0 0", busy_o, saw_ovalid);
        end
        total++;
        if (mem[1023] !== 8'hFF || mem[300] !== 8'h2C) begin
            bad++;
            $display("FAIL full_ram: got [1023]=%h [300]=%h want ff 2c", mem[1023], mem[300]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_fill();
        test_dump(4, 1'b0);
        test_dump(4, 1'b1);
        test_len_zero_both();
        test_full_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
